phys_reg_free_list: RTL and testbench
=====================================

Name: phys_reg_free_list

Overview:
- Circular free list of physical register numbers for the rename stage.
- Hands out up to ALLOC_WIDTH free pregs per cycle to rename.
- Reclaims the previous mapping of every committed destination. This is the same commit stream that updates the architectural RAT.
- Keeps an architectural head pointer so a pipeline flush restores the speculative free state in one cycle.

Parameters:
- PHY_REG_NUM, 64: number of physical registers. Must be a power of two. Preg 0 is the permanent reset mapping and is never allocated.
- ALLOC_WIDTH, 2: rename slots per cycle. Equals `DECODE_WIDTH.
- FREE_WIDTH, 2: commit slots per cycle.
- PW (localparam) = $clog2(PHY_REG_NUM).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- alloc_req_i  in  ALLOC_WIDTH  per-slot request; slot i needs a destination preg
- alloc_ready_o  out  1  list holds at least ALLOC_WIDTH free entries
- alloc_preg_o  out  ALLOC_WIDTH x PW  preg granted to each requesting slot
- commit_valid_i  in  FREE_WIDTH  per-slot commit of an instruction with a destination
- commit_old_preg_i  in  FREE_WIDTH x PW  previous preg mapping of the committed destination; returned to the list
- flush_i  in  1  squash all uncommitted renames
- free_cnt_o  out  PW+1  current speculative free count
- err_o  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Storage: PHY_REG_NUM entries x PW bits. Pointers head, tail, arch_head are each PW+1 bits, with the top bit as the wrap bit. Index = low PW bits.
- Count:
  - free_cnt = tail - head, taken mod 2^(PW+1).
  - alloc_ready_o = (free_cnt >= ALLOC_WIDTH).
  - alloc_ready_o is registered-state only. It has no combinational path from any input.
- Reset (rst=1 at a clk edge):
  - entry[k] = k+1 for k < PHY_REG_NUM-1.
  - head = 0, arch_head = 0, tail = PHY_REG_NUM-1.
  - free_cnt_o = 63, alloc_ready_o = 1, err_o = 0.
  - alloc_preg_o[i] = i+1.
- Allocation (combinational read, zero latency):
  - Slot i receives entry[head + popcount(alloc_req_i[i-1:0])].
  - alloc_preg_o is always driven this way. Its value is don't-care for non-requesting slots.
  - Fire = alloc_ready_o & |alloc_req_i & ~flush_i.
  - On fire: head += popcount(alloc_req_i) at the next edge.
  - With alloc_ready_o = 0: requests are ignored and head is unchanged. Rename must stall.
- Commit free:
  - For each slot with commit_valid_i set and commit_old_preg_i != 0, write the preg at tail + (number of earlier such slots).
  - tail advances by that number.
  - A preg 0 value is dropped and not pushed.
  - arch_head += popcount(commit_valid_i). This includes slots whose old preg is 0, because each committed dest consumed one allocation.
- Simultaneous alloc and free in one cycle:
  - Both pointer updates apply.
  - Freed entries become allocatable from the next cycle; no bypass.
- Flush:
  - At the next edge, head <= arch_head_next, where arch_head_next includes the same-cycle commit increment.
  - Same-cycle commits still push to tail.
  - Allocation is suppressed in the flush cycle.
- Wrap-around: all pointer arithmetic is mod 2^(PW+1). The index wraps naturally at PHY_REG_NUM.
- Overflow (free_cnt exceeding PHY_REG_NUM-1) cannot occur in a correct pipeline. Behaviour is defined only via err_o.
- Reset mid-operation: all state returns to the reset values above on the next edge, regardless of inputs.

Optional Feature:
- Macro: FREE_LIST_CHECK_EN.
- With it defined:
  - A PHY_REG_NUM-bit in-list bitmap is maintained. Reset value: bit k = 1 for k >= 1.
  - Allocation clears bits; free sets bits; flush rebuilds the bitmap from the entries in [arch_head, tail).
  - err_o is set sticky on any of: freeing a preg whose bit is already set; two slots freeing the same preg in one cycle; allocation while free_cnt < popcount(req).
  - err_o is cleared only by rst.
- Without it: no bitmap; err_o is tied to 0.

Test Plan:
1. Release reset -> free_cnt_o=63, alloc_ready_o=1, alloc_preg_o[0]=1, alloc_preg_o[1]=2, err_o=0.
2. alloc_req_i=2'b10 for one cycle -> alloc_preg_o[1]=1 in that cycle; next cycle head=1, free_cnt_o=62, alloc_preg_o[0]=2.
3. Request 2'b11 every cycle for 31 cycles -> free_cnt_o=1, alloc_ready_o=0. Further requests leave head and alloc_preg_o unchanged.
4. commit_valid_i=2'b11 with old pregs {0,5} -> only 5 is written at tail; free_cnt_o +1; arch_head +2.
5. Allocate 10 pregs, commit 4 (all old pregs 0), then flush_i -> next cycle head=arch_head=4, free_cnt_o=59, alloc_preg_o[0]=5.
6. With FREE_LIST_CHECK_EN: free preg 7 while it is still in the list -> err_o=1 next cycle and stays 1 until rst.

Source files
------------

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular free list of physical register numbers for rename.
//   Hands out up to ALLOC_WIDTH pregs per cycle (combinational read at head),
//   reclaims the old mapping of each committed destination at tail, and keeps an
//   architectural head so a flush restores the speculative free state in one cycle.
// Latency: alloc_preg_o is zero-latency; pointer/count updates take effect next edge.
// Backpressure: alloc_ready_o (registered state only) must be high for requests to fire;
//   otherwise requests are ignored and rename must stall. Commits are never refused.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   alloc_req_i         per-slot allocation request
//   alloc_ready_o       at least ALLOC_WIDTH entries free
//   alloc_preg_o        preg offered to each slot (slot i at [i*PW +: PW])
//   commit_valid_i      per-slot commit of an instruction with a destination
//   commit_old_preg_i   old mapping returned to the list (preg 0 is dropped)
//   flush_i             squash all uncommitted renames
//   free_cnt_o          speculative free count
//   err_o               sticky consistency error
// Optional: define FREE_LIST_CHECK_EN to enable the in-list bitmap checker driving err_o;
//   without it err_o is tied low.
module phys_reg_free_list #(
   parameter int PHY_REG_NUM = 64,
   parameter int ALLOC_WIDTH = 2,
   parameter int FREE_WIDTH  = 2,
   localparam int PW = $clog2(PHY_REG_NUM)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ALLOC_WIDTH-1:0]      alloc_req_i,
   output logic                        alloc_ready_o,
   output logic [ALLOC_WIDTH*PW-1:0]   alloc_preg_o,
   input  logic [FREE_WIDTH-1:0]       commit_valid_i,
   input  logic [FREE_WIDTH*PW-1:0]    commit_old_preg_i,
   input  logic                        flush_i,
   output logic [PW:0]                 free_cnt_o,
   output logic                        err_o
);

   logic [PW-1:0] entry [PHY_REG_NUM];

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [PW:0] head, tail, arch_head;
   logic [PW:0] head_nxt, tail_nxt, arch_head_nxt;
   logic [PW:0] free_cnt;
   logic [PW:0] alloc_cnt, push_cnt, commit_cnt;
   logic [PW-1:0] wr_idx [FREE_WIDTH];
   logic [FREE_WIDTH-1:0] wr_en;
   logic fire;

   assign free_cnt      = tail - head;
   assign free_cnt_o    = free_cnt;
   assign alloc_ready_o = (free_cnt >= (PW+1)'(ALLOC_WIDTH));

   // Slot i takes the entry skipped past by the requesting slots below it.
   always_comb begin
      alloc_cnt    = '0;
      alloc_preg_o = '0;
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
         alloc_preg_o[i*PW +: PW] = entry[head[PW-1:0] + alloc_cnt[PW-1:0]];
         alloc_cnt = alloc_cnt + {{PW{1'b0}}, alloc_req_i[i]};
      end
   end

   // Non-zero old pregs are packed contiguously at tail; every commit moves arch_head.
   always_comb begin
      push_cnt   = '0;
      commit_cnt = '0;
      for (int j = 0; j < FREE_WIDTH; j++) begin
         wr_en[j]  = commit_valid_i[j] && (commit_old_preg_i[j*PW +: PW] != '0);
         wr_idx[j] = tail[PW-1:0] + push_cnt[PW-1:0];
         push_cnt   = push_cnt + {{PW{1'b0}}, wr_en[j]};
         commit_cnt = commit_cnt + {{PW{1'b0}}, commit_valid_i[j]};
      end
   end

   assign fire          = alloc_ready_o && (|alloc_req_i) && !flush_i;
   assign tail_nxt      = tail + push_cnt;
   assign arch_head_nxt = arch_head + commit_cnt;

   // Flush rewinds to the committed head including this cycle's commits.
   always_comb begin
      head_nxt = head;
      if (flush_i)
         head_nxt = arch_head_nxt;
      else if (fire)
         head_nxt = head + alloc_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < PHY_REG_NUM; k++)
            entry[k] <= (k < PHY_REG_NUM-1) ? PW'(k+1) : '0;
         head      <= '0;
         arch_head <= '0;
         tail      <= (PW+1)'(PHY_REG_NUM-1);
      end else begin
         for (int j = 0; j < FREE_WIDTH; j++)
            if (wr_en[j])
               entry[wr_idx[j]] <= commit_old_preg_i[j*PW +: PW];
         head      <= head_nxt;
         arch_head <= arch_head_nxt;
         tail      <= tail_nxt;
      end
   end

`ifdef FREE_LIST_CHECK_EN
   logic [PHY_REG_NUM-1:0] in_list, in_list_nxt;
   logic [PW-1:0] entry_nxt [PHY_REG_NUM];
   logic [PW:0] live_cnt;
   logic err_q, err_nxt;

   always_comb begin
      entry_nxt = entry;
      for (int j = 0; j < FREE_WIDTH; j++)
         if (wr_en[j])
            entry_nxt[wr_idx[j]] = commit_old_preg_i[j*PW +: PW];

      in_list_nxt = in_list;
      err_nxt     = err_q;
      if (fire) begin
         for (int i = 0; i < ALLOC_WIDTH; i++)
            if (alloc_req_i[i])
               in_list_nxt[alloc_preg_o[i*PW +: PW]] = 1'b0;
         if (free_cnt < alloc_cnt)
            err_nxt = 1'b1;
      end
      for (int j = 0; j < FREE_WIDTH; j++) begin
         if (wr_en[j]) begin
            if (in_list[commit_old_preg_i[j*PW +: PW]])
               err_nxt = 1'b1;
            for (int m = 0; m < j; m++)
               if (wr_en[m] && (commit_old_preg_i[m*PW +: PW] == commit_old_preg_i[j*PW +: PW]))
                  err_nxt = 1'b1;
            in_list_nxt[commit_old_preg_i[j*PW +: PW]] = 1'b1;
         end
      end

      // After a flush the free set is exactly [arch_head, tail) of the updated list.
      live_cnt = tail_nxt - arch_head_nxt;
      if (flush_i) begin
         in_list_nxt = '0;
         for (int k = 0; k < PHY_REG_NUM; k++)
            if ((PW+1)'(k) < live_cnt)
               in_list_nxt[entry_nxt[arch_head_nxt[PW-1:0] + PW'(k)]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_list <= {{(PHY_REG_NUM-1){1'b1}}, 1'b0};
         err_q   <= 1'b0;
      end else begin
         in_list <= in_list_nxt;
         err_q   <= err_nxt;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;
   localparam int PW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    alloc_req_i;
   logic          alloc_ready_o;
   logic [11:0]   alloc_preg_o;
   logic [1:0]    commit_valid_i;
   logic [11:0]   commit_old_preg_i;
   logic          flush_i;
   logic [PW:0]   free_cnt_o;
   logic          err_o;
   logic [PW-1:0] pg0, pg1;

   int tests  = 0;
   int errors = 0;

   assign pg0 = alloc_preg_o[5:0];
   assign pg1 = alloc_preg_o[11:6];

   phys_reg_free_list dut (
      .clk(clk), .rst(rst),
      .alloc_req_i(alloc_req_i), .alloc_ready_o(alloc_ready_o), .alloc_preg_o(alloc_preg_o),
      .commit_valid_i(commit_valid_i), .commit_old_preg_i(commit_old_preg_i),
      .flush_i(flush_i), .free_cnt_o(free_cnt_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      alloc_req_i = '0; commit_valid_i = '0; commit_old_preg_i = '0; flush_i = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (free_cnt_o !== 7'd63) begin errors++; $display("FAIL reset_cnt got %0d exp 63", free_cnt_o); end
      tests++; if (alloc_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", alloc_ready_o); end
      alloc_req_i = 2'b11; #1;
      tests++; if (pg0 !== 6'd1) begin errors++; $display("FAIL reset_pg0 got %0d exp 1", pg0); end
      tests++; if (pg1 !== 6'd2) begin errors++; $display("FAIL reset_pg1 got %0d exp 2", pg1); end
      tests++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err_o); end
      alloc_req_i = 2'b00;
   endtask

   task automatic test_alloc_single();
      alloc_req_i = 2'b10; #1;
      tests++; if (pg1 !== 6'd1) begin errors++; $display("FAIL single_pg1 got %0d exp 1", pg1); end
      step();
      alloc_req_i = 2'b01; #1;
      tests++; if (free_cnt_o !== 7'd62) begin errors++; $display("FAIL single_cnt got %0d exp 62", free_cnt_o); end
      tests++; if (pg0 !== 6'd2) begin errors++; $display("FAIL single_pg0 got %0d exp 2", pg0); end
      alloc_req_i = 2'b00;
   endtask

   task automatic test_exhaust();
      do_reset();
      alloc_req_i = 2'b11;
      repeat (31) step();
      tests++; if (free_cnt_o !== 7'd1) begin errors++; $display("FAIL exhaust_cnt got %0d exp 1", free_cnt_o); end
      tests++; if (alloc_ready_o !== 1'b0) begin errors++; $display("FAIL exhaust_ready got %0b exp 0", alloc_ready_o); end
      tests++; if (pg0 !== 6'd63) begin errors++; $display("FAIL exhaust_pg0 got %0d exp 63", pg0); end
      repeat (2) step();
      tests++; if (free_cnt_o !== 7'd1) begin errors++; $display("FAIL stall_cnt got %0d exp 1", free_cnt_o); end
      tests++; if (pg0 !== 6'd63) begin errors++; $display("FAIL stall_pg0 got %0d exp 63", pg0); end
      alloc_req_i = 2'b00;
   endtask

   // Continues from the exhausted state: head=62, tail=63, arch_head=0.
   task automatic test_commit_zero();
      commit_valid_i = 2'b11; commit_old_preg_i = {6'd0, 6'd5};
      step();
      clear_inputs(); #1;
      tests++; if (free_cnt_o !== 7'd2) begin errors++; $display("FAIL czero_cnt got %0d exp 2", free_cnt_o); end
      tests++; if (alloc_ready_o !== 1'b1) begin errors++; $display("FAIL czero_ready got %0b exp 1", alloc_ready_o); end
      alloc_req_i = 2'b11; #1;
      tests++; if (pg1 !== 6'd5) begin errors++; $display("FAIL czero_pg1 got %0d exp 5", pg1); end
      alloc_req_i = 2'b00; flush_i = 1'b1;
      step();
      clear_inputs(); #1;
      // arch_head advanced by 2 even though only one preg was pushed.
      tests++; if (free_cnt_o !== 7'd62) begin errors++; $display("FAIL czero_flush_cnt got %0d exp 62", free_cnt_o); end
      tests++; if (pg0 !== 6'd3) begin errors++; $display("FAIL czero_flush_pg0 got %0d exp 3", pg0); end
   endtask

   task automatic test_flush();
      do_reset();
      alloc_req_i = 2'b11;
      repeat (5) step();
      alloc_req_i = 2'b00;
      tests++; if (free_cnt_o !== 7'd53) begin errors++; $display("FAIL flush_pre_cnt got %0d exp 53", free_cnt_o); end
      commit_valid_i = 2'b11; commit_old_preg_i = '0;
      repeat (2) step();
      clear_inputs(); flush_i = 1'b1;
      step();
      clear_inputs(); #1;
      tests++; if (free_cnt_o !== 7'd59) begin errors++; $display("FAIL flush_cnt got %0d exp 59", free_cnt_o); end
      tests++; if (pg0 !== 6'd5) begin errors++; $display("FAIL flush_pg0 got %0d exp 5", pg0); end
   endtask

   task automatic test_flush_commit();
      do_reset();
      alloc_req_i = 2'b11;
      repeat (3) step();
      commit_valid_i = 2'b11; commit_old_preg_i = {6'd31, 6'd30}; flush_i = 1'b1;
      step();
      clear_inputs(); #1;
      // head <- 2, tail <- 65, allocation in the flush cycle suppressed.
      tests++; if (free_cnt_o !== 7'd63) begin errors++; $display("FAIL fcommit_cnt got %0d exp 63", free_cnt_o); end
      tests++; if (pg0 !== 6'd3) begin errors++; $display("FAIL fcommit_pg0 got %0d exp 3", pg0); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      alloc_req_i = 2'b11; commit_valid_i = 2'b01; commit_old_preg_i = {6'd0, 6'd9};
      step();
      clear_inputs(); #1;
      tests++; if (free_cnt_o !== 7'd62) begin errors++; $display("FAIL b2b_cnt got %0d exp 62", free_cnt_o); end
      tests++; if (pg0 !== 6'd3) begin errors++; $display("FAIL b2b_pg0 got %0d exp 3", pg0); end
   endtask

   task automatic test_wrap();
      do_reset();
      alloc_req_i = 2'b11;
      repeat (31) step();
      clear_inputs();
      commit_valid_i = 2'b11; commit_old_preg_i = {6'd21, 6'd20};
      step();
      clear_inputs(); #1;
      tests++; if (free_cnt_o !== 7'd3) begin errors++; $display("FAIL wrap_cnt got %0d exp 3", free_cnt_o); end
      alloc_req_i = 2'b11; #1;
      tests++; if (pg0 !== 6'd63) begin errors++; $display("FAIL wrap_pg0 got %0d exp 63", pg0); end
      tests++; if (pg1 !== 6'd20) begin errors++; $display("FAIL wrap_pg1 got %0d exp 20", pg1); end
      step();
      alloc_req_i = 2'b01; #1;
      tests++; if (free_cnt_o !== 7'd1) begin errors++; $display("FAIL wrap_cnt2 got %0d exp 1", free_cnt_o); end
      tests++; if (pg0 !== 6'd21) begin errors++; $display("FAIL wrap_pg0b got %0d exp 21", pg0); end
      alloc_req_i = 2'b00;
   endtask

   task automatic test_mid_reset();
      alloc_req_i = 2'b11; commit_valid_i = 2'b11; commit_old_preg_i = {6'd3, 6'd4}; flush_i = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0; clear_inputs();
      alloc_req_i = 2'b01; #1;
      tests++; if (free_cnt_o !== 7'd63) begin errors++; $display("FAIL midrst_cnt got %0d exp 63", free_cnt_o); end
      tests++; if (pg0 !== 6'd1) begin errors++; $display("FAIL midrst_pg0 got %0d exp 1", pg0); end
      tests++; if (pg1 !== 6'd2) begin errors++; $display("FAIL midrst_pg1 got %0d exp 2", pg1); end
      alloc_req_i = 2'b00;
   endtask

   task automatic test_err();
      do_reset();
      commit_valid_i = 2'b01; commit_old_preg_i = {6'd0, 6'd7};
      step();
      clear_inputs(); #1;
`ifdef FREE_LIST_CHECK_EN
      tests++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set got %0b exp 1", err_o); end
      repeat (3) step();
      tests++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b exp 1", err_o); end
      do_reset();
      tests++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear got %0b exp 0", err_o); end
`else
      tests++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_tied got %0b exp 0", err_o); end
`endif
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_alloc_single();
      test_exhaust();
      test_commit_zero();
      test_flush();
      test_flush_commit();
      test_back_to_back();
      test_wrap();
      test_mid_reset();
      test_err();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
